// File: rtl/add_errmon_pkg.sv
// Shared types and width helpers for the approximate-adder error monitor.
package add_errmon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } errmon_state_t;

  function automatic int unsigned res_width(input int unsigned w);
    return w + 1;
  endfunction

  function automatic int unsigned sae_width(input int unsigned w, input int unsigned cw);
    return w + 1 + cw;
  endfunction

  function automatic int unsigned sse_width(input int unsigned w, input int unsigned cw);
    return 2 * (w + 1) + cw;
  endfunction

endpackage

// File: rtl/add_errmon_absdiff.sv
// Exact W-bit sum and absolute difference |o - (a+b)|, purely combinational.
module add_errmon_absdiff
  import add_errmon_pkg::*;
#(
  parameter int unsigned W = 12
) (
  input  logic [W-1:0]              a,
  input  logic [W-1:0]              b,
  input  logic [res_width(W)-1:0]   o,
  output logic [res_width(W)-1:0]   d,
  output logic                      err
);

  logic [res_width(W)-1:0] exact;

  // Both operands fit in W+1 bits, so the magnitude is taken by ordering
  // the subtraction rather than negating a W+2 signed difference.
  always_comb begin
    exact = {1'b0, a} + {1'b0, b};
    d     = (o < exact) ? (exact - o) : (o - exact);
    err   = (o != exact);
  end

endmodule

// File: rtl/add12u_err_monitor.sv
// Streaming error statistics (error count, SAE, WCE) for 12-bit approximate adders.
// Optional sum of squared error output enabled by ADD_ERRMON_MSE_EN.
module add12u_err_monitor
  import add_errmon_pkg::*;
#(
  parameter int unsigned W  = 12,
  parameter int unsigned CW = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [CW-1:0]                 n_samples,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [W-1:0]                  in_a,
  input  logic [W-1:0]                  in_b,
  input  logic [res_width(W)-1:0]       in_o,
  output logic                          busy,
  output logic                          done,
  output logic [CW-1:0]                 err_cnt,
  output logic [sae_width(W, CW)-1:0]   sae,
  output logic [res_width(W)-1:0]       wce,
  output logic [W-1:0]                  wce_a,
  output logic [W-1:0]                  wce_b,
  output logic [CW-1:0]                 acc_cnt
`ifdef ADD_ERRMON_MSE_EN
  ,
  output logic [sse_width(W, CW)-1:0]   sse
`endif
);

  localparam int unsigned RW = res_width(W);
  localparam int unsigned SW = sae_width(W, CW);
  localparam logic [CW-1:0] ONE = CW'(1);

  errmon_state_t state, state_nxt;

  logic [CW-1:0] target;
  logic          in_ready_nxt;
  logic          start_acc;
  logic          xfer;
  logic          last_xfer;

  logic [RW-1:0] d_c;
  logic          err_c;

  logic          s1_valid;
  logic          s1_err;
  logic [RW-1:0] s1_d;
  logic [W-1:0]  s1_a;
  logic [W-1:0]  s1_b;

  add_errmon_absdiff #(.W(W)) u_absdiff (
    .a   (in_a),
    .b   (in_b),
    .o   (in_o),
    .d   (d_c),
    .err (err_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    start_acc    = 1'b0;
    in_ready_nxt = 1'b0;
    xfer         = in_valid && in_ready;
    last_xfer    = xfer && ((acc_cnt + ONE) == target);
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          start_acc = 1'b1;
          if (n_samples == '0) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt    = ST_RUN;
            in_ready_nxt = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (last_xfer) state_nxt    = ST_DRAIN;
        else           in_ready_nxt = 1'b1;
      end
      ST_DRAIN: begin
        // S2 is the accumulator itself, so an empty S1 means drained.
        if (!s1_valid) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_RUN) || (state == ST_DRAIN);
    done = (state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready <= 1'b0;
      target   <= '0;
      acc_cnt  <= '0;
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_d     <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      err_cnt  <= '0;
      sae      <= '0;
      wce      <= '0;
      wce_a    <= '0;
      wce_b    <= '0;
    end else begin
      in_ready <= in_ready_nxt;
      s1_valid <= xfer;
      if (xfer) begin
        s1_err <= err_c;
        s1_d   <= d_c;
        s1_a   <= in_a;
        s1_b   <= in_b;
      end
      if (start_acc) begin
        target  <= n_samples;
        acc_cnt <= '0;
        err_cnt <= '0;
        sae     <= '0;
        wce     <= '0;
        wce_a   <= '0;
        wce_b   <= '0;
      end else begin
        if (xfer) acc_cnt <= acc_cnt + ONE;
        if (s1_valid) begin
          err_cnt <= err_cnt + CW'(s1_err);
          sae     <= sae + SW'(s1_d);
          // Strictly greater only: ties keep the earliest operands.
          if (s1_d > wce) begin
            wce   <= s1_d;
            wce_a <= s1_a;
            wce_b <= s1_b;
          end
        end
      end
    end
  end

`ifdef ADD_ERRMON_MSE_EN
  localparam int unsigned QW  = 2 * RW;
  localparam int unsigned SSW = sse_width(W, CW);

  logic [QW-1:0] s1_sq;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_sq <= '0;
      sse   <= '0;
    end else begin
      if (xfer) s1_sq <= QW'(d_c) * QW'(d_c);
      if (start_acc)     sse <= '0;
      else if (s1_valid) sse <= sse + SSW'(s1_sq);
    end
  end
`endif

endmodule

// File: tb/tb_add12u_err_monitor.sv
// Directed self-checking bench for add12u_err_monitor (ADD_ERRMON_MSE_EN aware).
module tb_add12u_err_monitor;

  localparam int unsigned W  = 12;
  localparam int unsigned CW = 16;
  localparam int unsigned RW = W + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [CW-1:0]     n_samples;
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      in_a;
  logic [W-1:0]      in_b;
  logic [RW-1:0]     in_o;
  logic              busy;
  logic              done;
  logic [CW-1:0]     err_cnt;
  logic [RW+CW-1:0]  sae;
  logic [RW-1:0]     wce;
  logic [W-1:0]      wce_a;
  logic [W-1:0]      wce_b;
  logic [CW-1:0]     acc_cnt;
`ifdef ADD_ERRMON_MSE_EN
  logic [2*RW+CW-1:0] sse;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  add12u_err_monitor #(.W(W), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .n_samples (n_samples),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_o      (in_o),
    .busy      (busy),
    .done      (done),
    .err_cnt   (err_cnt),
    .sae       (sae),
    .wce       (wce),
    .wce_a     (wce_a),
    .wce_b     (wce_b),
    .acc_cnt   (acc_cnt)
`ifdef ADD_ERRMON_MSE_EN
    ,
    .sse       (sse)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n);
    start     = 1'b1;
    n_samples = CW'(n);
    tick();
    start     = 1'b0;
  endtask

  // Holds in_valid high afterwards so consecutive sends run back-to-back.
  task automatic send(input int a, input int b, input int o);
    int k;
    in_valid = 1'b1;
    in_a     = W'(a);
    in_b     = W'(b);
    in_o     = RW'(o);
    k = 0;
    while (!in_ready && k < 20) begin
      tick();
      k++;
    end
    if (!in_ready) check_eq("send_ready_timeout", 64'(in_ready), 64'd1);
    else           tick();
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    int xf;
    rst = 1'b1; start = 1'b0; n_samples = '0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_o = '0;
    tick(); tick();
    rst = 1'b0;
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    check_eq("rst_busy",     64'(busy),     64'd0);
    check_eq("rst_done",     64'(done),     64'd0);
    check_eq("rst_err_cnt",  64'(err_cnt),  64'd0);
    check_eq("rst_sae",      64'(sae),      64'd0);
    check_eq("rst_wce",      64'(wce),      64'd0);
    check_eq("rst_acc_cnt",  64'(acc_cnt),  64'd0);

    // Exact results, full throughput
    do_start(4);
    check_eq("ex_busy",     64'(busy),     64'd1);
    check_eq("ex_in_ready", 64'(in_ready), 64'd1);
    send(1, 2, 3); send(4095, 4095, 8190); send(0, 0, 0); send(100, 28, 128);
    in_valid = 1'b0;
    check_eq("ex_ready_drop", 64'(in_ready), 64'd0);
    wait_done(c);
    check_eq("ex_done_lat", 64'(c),       64'd2);
    check_eq("ex_err_cnt",  64'(err_cnt), 64'd0);
    check_eq("ex_sae",      64'(sae),     64'd0);
    check_eq("ex_wce",      64'(wce),     64'd0);
    check_eq("ex_acc_cnt",  64'(acc_cnt), 64'd4);
    check_eq("ex_busy_end", 64'(busy),    64'd0);

    // Single error, last sample; restart from DONE
    do_start(3);
    check_eq("se_done_fall", 64'(done),    64'd0);
    check_eq("se_acc_clr",   64'(acc_cnt), 64'd0);
    send(5, 6, 11); send(7, 8, 15); send(16, 16, 33);
    in_valid = 1'b0;
    check_eq("se_lat1_err", 64'(err_cnt), 64'd0);
    tick();
    check_eq("se_lat2_err", 64'(err_cnt), 64'd1);
    wait_done(c);
    check_eq("se_done_lat", 64'(c),     64'd1);
    check_eq("se_sae",      64'(sae),   64'd1);
    check_eq("se_wce",      64'(wce),   64'd1);
    check_eq("se_wce_a",    64'(wce_a), 64'd16);
    check_eq("se_wce_b",    64'(wce_b), 64'd16);

    // Mixed signs: d=5 then d=3
    do_start(2);
    send(0, 0, 5); send(10, 10, 17);
    in_valid = 1'b0;
    wait_done(c);
    check_eq("mx_err_cnt", 64'(err_cnt), 64'd2);
    check_eq("mx_sae",     64'(sae),     64'd8);
    check_eq("mx_wce",     64'(wce),     64'd5);
    check_eq("mx_wce_a",   64'(wce_a),   64'd0);
    check_eq("mx_wce_b",   64'(wce_b),   64'd0);
`ifdef ADD_ERRMON_MSE_EN
    check_eq("mx_sse",     64'(sse),     64'd34);
`endif

    // Tie on wce keeps the earliest operands
    do_start(2);
    send(1, 1, 3); send(2, 2, 3);
    in_valid = 1'b0;
    wait_done(c);
    check_eq("tie_wce",   64'(wce),   64'd1);
    check_eq("tie_wce_a", 64'(wce_a), 64'd1);
    check_eq("tie_wce_b", 64'(wce_b), 64'd1);
    check_eq("tie_sae",   64'(sae),   64'd2);

    // Backpressure: valid every other cycle, a 6th valid triple is refused
    do_start(5);
    xf = 0;
    for (int k = 0; k < 16; k++) begin
      in_valid = ((k % 2) == 0);
      in_a     = W'(k);
      in_b     = W'(k);
      in_o     = RW'(2 * k);
      if (in_valid && in_ready) xf++;
      tick();
    end
    check_eq("bp_xfers",    64'(xf),       64'd5);
    check_eq("bp_acc_cnt",  64'(acc_cnt),  64'd5);
    check_eq("bp_in_ready", 64'(in_ready), 64'd0);
    check_eq("bp_done",     64'(done),     64'd1);
    check_eq("bp_err_cnt",  64'(err_cnt),  64'd0);
    in_valid = 1'b0;

    // n = 0 completes one cycle after start
    do_start(0);
    check_eq("z_done",     64'(done),     64'd1);
    check_eq("z_busy",     64'(busy),     64'd0);
    check_eq("z_acc_cnt",  64'(acc_cnt),  64'd0);
    check_eq("z_in_ready", 64'(in_ready), 64'd0);
    check_eq("z_sae",      64'(sae),      64'd0);

    // start during RUN is ignored
    do_start(3);
    send(1, 1, 5);
    in_valid  = 1'b0;
    start     = 1'b1;
    n_samples = CW'(1);
    tick();
    start = 1'b0;
    check_eq("ir_busy",    64'(busy),    64'd1);
    check_eq("ir_acc_cnt", 64'(acc_cnt), 64'd1);
    send(2, 2, 4); send(3, 3, 6);
    in_valid = 1'b0;
    wait_done(c);
    check_eq("ir_done",    64'(done),    64'd1);
    check_eq("ir_acc_end", 64'(acc_cnt), 64'd3);
    check_eq("ir_err_cnt", 64'(err_cnt), 64'd1);
    check_eq("ir_sae",     64'(sae),     64'd3);
    check_eq("ir_wce_a",   64'(wce_a),   64'd1);

    // Reset mid-run after 2 of 4 samples
    do_start(4);
    send(7, 7, 1); send(9, 9, 0);
    check_eq("mr_acc_pre", 64'(acc_cnt), 64'd2);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mr_busy",     64'(busy),     64'd0);
    check_eq("mr_done",     64'(done),     64'd0);
    check_eq("mr_in_ready", 64'(in_ready), 64'd0);
    check_eq("mr_acc_cnt",  64'(acc_cnt),  64'd0);
    check_eq("mr_err_cnt",  64'(err_cnt),  64'd0);
    check_eq("mr_wce",      64'(wce),      64'd0);
    tick(); tick();
    check_eq("mr_sae_hold", 64'(sae),      64'd0);
    check_eq("mr_err_hold", 64'(err_cnt),  64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
